// File: rtl/regfile_pkg.sv
// Shared widths, well-known register indices and types for the integer register file.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [REG_ADDR_W-1:0] A0_REG   = 5'd10;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by issue-stage locks, cleared by write-back.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int NUM_READ      = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              write_en_i,
  input  logic [ADDRESS_WIDTH-1:0]          write_addr_i,
  input  logic                              lock_en_i,
  input  logic [ADDRESS_WIDTH-1:0]          lock_addr_i,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] read_addr_i,
  output logic [NUM_READ-1:0]               lookup_o
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [DEPTH-1:0] pending_q;
  logic [DEPTH-1:0] pending_d;

  // Clear first, then set: a new producer issued in the write-back cycle keeps the bit high.
  always_comb begin
    pending_d = pending_q;
    if (write_en_i && (write_addr_i != '0)) begin
      pending_d[write_addr_i] = 1'b0;
    end
    if (lock_en_i && (lock_addr_i != '0)) begin
      pending_d[lock_addr_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Lookups see the post-update vector so they line up with the write-first read data.
  for (genvar k = 0; k < NUM_READ; k++) begin : g_lookup
    assign lookup_o[k] = pending_d[read_addr_i[k*ADDRESS_WIDTH +: ADDRESS_WIDTH]];
  end

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: NUM_READ registered write-first read ports, one write port,
// hardwired x0, pending-write scoreboard and a registered tap of one architectural register.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int ADDRESS_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH    = REG_DATA_W,
  parameter int NUM_READ      = 2,
  parameter int TAP_REG       = int'(A0_REG)
) (
  input  logic                              iClk,
  input  logic                              iRst,
  input  logic                              iWriteEn,
  input  logic [ADDRESS_WIDTH-1:0]          iWriteAddress,
  input  logic [DATA_WIDTH-1:0]             iDataIn,
  input  logic [NUM_READ*ADDRESS_WIDTH-1:0] iReadAddress,
  input  logic                              iLockEn,
  input  logic [ADDRESS_WIDTH-1:0]          iLockAddress,
  output logic [NUM_READ*DATA_WIDTH-1:0]    oRegData,
  output logic [NUM_READ-1:0]               oPending,
  output logic [DATA_WIDTH-1:0]             oTapData
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  localparam logic [ADDRESS_WIDTH-1:0] TAP_ADDR = ADDRESS_WIDTH'(TAP_REG);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_d [NUM_READ];
  logic [DATA_WIDTH-1:0] rdata_q [NUM_READ];
  logic [NUM_READ-1:0]   pending_d;
  logic [NUM_READ-1:0]   pending_q;
  logic [DATA_WIDTH-1:0] tap_d;
  logic [DATA_WIDTH-1:0] tap_q;
  logic                  write_live;

  assign write_live = iWriteEn && (iWriteAddress != '0);

  // Entry 0 is never written, so it always holds zero.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (write_live) begin
      mem_q[iWriteAddress] <= iDataIn;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_read
    logic [ADDRESS_WIDTH-1:0] raddr;
    assign raddr = iReadAddress[k*ADDRESS_WIDTH +: ADDRESS_WIDTH];

    always_comb begin
      rdata_d[k] = mem_q[raddr];
      if (raddr == '0) begin
        rdata_d[k] = '0;
      end else if (write_live && (iWriteAddress == raddr)) begin
        rdata_d[k] = iDataIn;
      end
    end

    assign oRegData[k*DATA_WIDTH +: DATA_WIDTH] = rdata_q[k];
  end

  always_comb begin
    tap_d = mem_q[TAP_ADDR];
    if (write_live && (iWriteAddress == TAP_ADDR)) begin
      tap_d = iDataIn;
    end
  end

  regfile_scoreboard #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .NUM_READ      (NUM_READ)
  ) u_scoreboard (
    .clk_i        (iClk),
    .rst_i        (iRst),
    .write_en_i   (iWriteEn),
    .write_addr_i (iWriteAddress),
    .lock_en_i    (iLockEn),
    .lock_addr_i  (iLockAddress),
    .read_addr_i  (iReadAddress),
    .lookup_o     (pending_d)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      for (int k = 0; k < NUM_READ; k++) begin
        rdata_q[k] <= '0;
      end
      pending_q <= '0;
      tap_q     <= '0;
    end else begin
      for (int k = 0; k < NUM_READ; k++) begin
        rdata_q[k] <= rdata_d[k];
      end
      pending_q <= pending_d;
      tap_q     <= tap_d;
    end
  end

  assign oPending = pending_q;
  assign oTapData = tap_q;

endmodule

// File: tb/tb_regfile_multiport.sv
// Randomized and directed bench for regfile_multiport (three read ports) against an
// architectural model: registers and pending bits as plain arrays, reads return post-edge state.
module tb_regfile_multiport;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 3;
  localparam int TAP   = 10;
  localparam int DEPTH = 2 ** AW;

  // clock / reset
  logic iClk = 1'b0;
  always #5 iClk = ~iClk;

  logic               iRst;
  logic               iWriteEn;
  logic [AW-1:0]      iWriteAddress;
  logic [DW-1:0]      iDataIn;
  logic [NR*AW-1:0]   iReadAddress;
  logic               iLockEn;
  logic [AW-1:0]      iLockAddress;
  logic [NR*DW-1:0]   oRegData;
  logic [NR-1:0]      oPending;
  logic [DW-1:0]      oTapData;

  regfile_multiport #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .NUM_READ      (NR),
    .TAP_REG       (TAP)
  ) dut (
    .iClk          (iClk),
    .iRst          (iRst),
    .iWriteEn      (iWriteEn),
    .iWriteAddress (iWriteAddress),
    .iDataIn       (iDataIn),
    .iReadAddress  (iReadAddress),
    .iLockEn       (iLockEn),
    .iLockAddress  (iLockAddress),
    .oRegData      (oRegData),
    .oPending      (oPending),
    .oTapData      (oTapData)
  );

  // scoreboard / reference model
  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] m_reg  [DEPTH];
  bit            m_pend [DEPTH];
  logic [DW-1:0] exp_q[$];

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver: present one cycle of inputs, advance the model across the edge, check all outputs
  task automatic step(input bit rst, input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit le, input logic [AW-1:0] la,
                      input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic [AW-1:0] ra [NR];
    ra[0] = r0;
    ra[1] = r1;
    ra[2] = r2;
    iRst          = rst;
    iWriteEn      = we;
    iWriteAddress = wa;
    iDataIn       = wd;
    iLockEn       = le;
    iLockAddress  = la;
    iReadAddress  = {r2, r1, r0};
    @(posedge iClk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = '0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (we && wa != 0) begin
        m_reg[wa]  = wd;
        m_pend[wa] = 1'b0;
      end
      if (le && la != 0) m_pend[la] = 1'b1;
    end
    for (int k = 0; k < NR; k++) exp_q.push_back(m_reg[ra[k]]);
    for (int k = 0; k < NR; k++) exp_q.push_back({{(DW-1){1'b0}}, m_pend[ra[k]]});
    exp_q.push_back(m_reg[TAP]);
    #1;
    for (int k = 0; k < NR; k++)
      check_val($sformatf("data%0d_x%0d", k, ra[k]), oRegData[k*DW +: DW], exp_q.pop_front());
    for (int k = 0; k < NR; k++)
      check_val($sformatf("pend%0d_x%0d", k, ra[k]), {{(DW-1){1'b0}}, oPending[k]}, exp_q.pop_front());
    check_val("tap", oTapData, exp_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end

    // 1: reset, then every address on all ports reads zero / not pending
    step(1, 1, 5'd3, 32'hFFFF_FFFF, 1, 5'd3, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int a = 0; a < DEPTH; a++) step(0, 0, 0, 0, 0, 0, a[AW-1:0], a[AW-1:0], a[AW-1:0]);
    check_val("t1_tap_zero", oTapData, 32'h0);

    // 2: write-first bypass, then a later read of the stored value
    step(0, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 5'd5, 5'd0, 5'd0);
    check_val("t2_bypass", oRegData[0 +: DW], 32'hDEAD_BEEF);
    step(0, 0, 0, 0, 0, 0, 5'd0, 5'd5, 5'd0);
    check_val("t2_stored", oRegData[DW +: DW], 32'hDEAD_BEEF);

    // 3: x0 write is dropped and x0 reads zero
    step(0, 1, 5'd0, 32'h1234_5678, 0, 0, 5'd0, 5'd0, 5'd0);
    check_val("t3_x0_p0", oRegData[0 +: DW], 32'h0);
    check_val("t3_x0_p1", oRegData[DW +: DW], 32'h0);

    // 4: lock, lock+write same register, then plain write-back
    step(0, 0, 0, 0, 1, 5'd7, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 0, 0, 5'd7, 5'd0, 5'd0);
    check_val("t4_locked", {31'b0, oPending[0]}, 32'h1);
    step(0, 1, 5'd7, 32'h55, 1, 5'd7, 5'd7, 5'd0, 5'd0);
    check_val("t4_lock_wins", {31'b0, oPending[0]}, 32'h1);
    check_val("t4_data", oRegData[0 +: DW], 32'h55);
    step(0, 1, 5'd7, 32'h66, 0, 0, 5'd7, 5'd0, 5'd0);
    check_val("t4_cleared", {31'b0, oPending[0]}, 32'h0);

    // 5: tap bypass, then reset beats a concurrent write
    step(0, 1, 5'd10, 32'd42, 0, 0, 5'd0, 5'd0, 5'd0);
    check_val("t5_tap", oTapData, 32'd42);
    step(1, 1, 5'd10, 32'd99, 0, 0, 5'd10, 5'd0, 5'd0);
    check_val("t5_tap_rst", oTapData, 32'd0);
    step(0, 0, 0, 0, 0, 0, 5'd10, 5'd0, 5'd0);
    check_val("t5_x10_rst", oRegData[0 +: DW], 32'd0);

    // 6: three independent ports
    step(0, 1, 5'd1, 32'd1, 0, 0, 0, 0, 0);
    step(0, 1, 5'd2, 32'd2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 5'd1, 5'd2, 5'd1);
    check_val("t6_p0", oRegData[0 +: DW], 32'd1);
    check_val("t6_p1", oRegData[DW +: DW], 32'd2);
    check_val("t6_p2", oRegData[2*DW +: DW], 32'd1);
    check_val("t6_pend", {29'b0, oPending}, 32'd0);

    // random traffic, addresses biased toward a small window to force collisions
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] a [5];
      for (int j = 0; j < 5; j++)
        a[j] = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH-1));
      step($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1, a[0], $urandom,
           $urandom_range(0, 2) == 0, a[1], a[2], a[3], a[4]);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
